palm_bbox_detector: RTL and testbench

Streaming palm bounding-box extractor: consumes a raster-ordered, one-bit skin-mask pixel stream and, once per frame, publishes the palm's start/end row/column and width/height. Sits directly upstream of the finger-identification stage. Its 8-bit box outputs feed that stage's `palm_width`, `palm_height`, `start_of_palm_r/c` and `end_of_palm_r/c` inputs. A zero `palm_width` means no palm was found in the frame.

---
 rtl/palm_bbox_detector.sv | 148 ++++++++++++++
 tb/tb_palm_bbox_detector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/palm_bbox_detector.sv
// Streaming palm bounding-box extractor over a raster-ordered one-bit skin mask.
// Optional horizontal run filter: define PALM_RUN_FILTER_EN.
module palm_bbox_detector #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int MIN_RUN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_valid,
    input  logic       pixel_skin,
    input  logic       frame_start,
    output logic [7:0] palm_width,
    output logic [7:0] palm_height,
    output logic [7:0] start_of_palm_r,
    output logic [7:0] start_of_palm_c,
    output logic [7:0] end_of_palm_r,
    output logic [7:0] end_of_palm_c,
    output logic       box_valid,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [7:0] LAST_C = 8'(IMG_W - 1);
    localparam logic [7:0] LAST_R = 8'(IMG_H - 1);

    state_t     state_q, state_d;
    logic [7:0] row_q, col_q, cur_r, cur_c, cmp_c;
    logic [7:0] min_r_q, min_c_q, max_r_q, max_c_q;
    logic [7:0] min_r_d, min_c_d, max_r_d, max_c_d;
    logic       found_q, found_d;
    logic       entry, step, last_pix, counted;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'd1;
    endfunction

    // An entry pixel (frame_start) is always (0,0), whatever the state.
    always_comb begin
        entry    = pixel_valid && frame_start;
        step     = pixel_valid && !frame_start && (state_q == SCAN);
        cur_r    = entry ? 8'd0 : row_q;
        cur_c    = entry ? 8'd0 : col_q;
        last_pix = step && (row_q == LAST_R) && (col_q == LAST_C);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (entry) state_d = SCAN;
            SCAN:    if (entry) state_d = SCAN;
                     else if (last_pix) state_d = DONE;
            DONE:    state_d = entry ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef PALM_RUN_FILTER_EN
    logic [3:0] run_q, run_base, run_d;

    // The run restarts at column 0; the pixel completing MIN_RUN pulls min_c back to the run start.
    always_comb begin
        run_base = (cur_c == 8'd0) ? 4'd0 : run_q;
        run_d    = pixel_skin ? sat_inc4(run_base) : 4'd0;
        counted  = pixel_skin && (run_d >= 4'(MIN_RUN));
        cmp_c    = (run_d == 4'(MIN_RUN)) ? cur_c - 8'(MIN_RUN - 1) : cur_c;
    end

    always_ff @(posedge clk) begin
        if (rst)
            run_q <= 4'd0;
        else if (entry || step)
            run_q <= run_d;
    end
`else
    always_comb begin
        counted = pixel_skin && (MIN_RUN >= 1);
        cmp_c   = cur_c;
    end
`endif

    always_comb begin
        min_r_d = entry ? 8'hFF : min_r_q;
        min_c_d = entry ? 8'hFF : min_c_q;
        max_r_d = entry ? 8'h00 : max_r_q;
        max_c_d = entry ? 8'h00 : max_c_q;
        found_d = entry ? 1'b0  : found_q;
        if (counted) begin
            if (cur_r < min_r_d) min_r_d = cur_r;
            if (cmp_c < min_c_d) min_c_d = cmp_c;
            if (cur_r > max_r_d) max_r_d = cur_r;
            if (cur_c > max_c_d) max_c_d = cur_c;
            found_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            row_q           <= 8'd0;
            col_q           <= 8'd0;
            min_r_q         <= 8'hFF;
            min_c_q         <= 8'hFF;
            max_r_q         <= 8'h00;
            max_c_q         <= 8'h00;
            found_q         <= 1'b0;
            box_valid       <= 1'b0;
            palm_width      <= 8'd0;
            palm_height     <= 8'd0;
            start_of_palm_r <= 8'd0;
            start_of_palm_c <= 8'd0;
            end_of_palm_r   <= 8'd0;
            end_of_palm_c   <= 8'd0;
        end else begin
            state_q   <= state_d;
            box_valid <= (state_q == DONE);
            if (entry) begin
                row_q <= 8'd0;
                col_q <= 8'd1;
            end else if (step) begin
                if (col_q == LAST_C) begin
                    col_q <= 8'd0;
                    row_q <= row_q + 8'd1;
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end
            if (entry || step) begin
                min_r_q <= min_r_d;
                min_c_q <= min_c_d;
                max_r_q <= max_r_d;
                max_c_q <= max_c_d;
                found_q <= found_d;
            end
            // Publish reads the registered accumulators, so a same-cycle re-entry cannot disturb it.
            if (state_q == DONE) begin
                start_of_palm_r <= found_q ? min_r_q : 8'd0;
                start_of_palm_c <= found_q ? min_c_q : 8'd0;
                end_of_palm_r   <= found_q ? max_r_q : 8'd0;
                end_of_palm_c   <= found_q ? max_c_q : 8'd0;
                palm_width      <= found_q ? max_c_q - min_c_q + 8'd1 : 8'd0;
                palm_height     <= found_q ? max_r_q - min_r_q + 8'd1 : 8'd0;
            end
        end
    end

    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_palm_bbox_detector.sv
// Directed self-checking bench for palm_bbox_detector (16x12 frame, MIN_RUN=3).
module tb_palm_bbox_detector;
    localparam int W = 16;
    localparam int H = 12;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst, pixel_valid, pixel_skin, frame_start;
    logic [7:0] palm_width, palm_height;
    logic [7:0] start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c;
    logic       box_valid, busy;

    int vectors     = 0;
    int miscompares = 0;
    int bv_count    = 0;
    int c0;

    logic mask_a [H][W];
    logic mask_b [H][W];

    palm_bbox_detector #(.IMG_W(W), .IMG_H(H), .MIN_RUN(3)) dut (
        .clk(clk), .rst(rst),
        .pixel_valid(pixel_valid), .pixel_skin(pixel_skin), .frame_start(frame_start),
        .palm_width(palm_width), .palm_height(palm_height),
        .start_of_palm_r(start_of_palm_r), .start_of_palm_c(start_of_palm_c),
        .end_of_palm_r(end_of_palm_r), .end_of_palm_c(end_of_palm_c),
        .box_valid(box_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (box_valid) bv_count <= bv_count + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_box(input string tag, input int sr, input int sc, input int er,
                           input int ec, input int w, input int h);
        chk({tag, "_sr"}, 32'(start_of_palm_r), sr);
        chk({tag, "_sc"}, 32'(start_of_palm_c), sc);
        chk({tag, "_er"}, 32'(end_of_palm_r), er);
        chk({tag, "_ec"}, 32'(end_of_palm_c), ec);
        chk({tag, "_w"},  32'(palm_width), w);
        chk({tag, "_h"},  32'(palm_height), h);
    endtask

    task automatic clear_masks();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                mask_a[r][c] = 1'b0;
                mask_b[r][c] = 1'b0;
            end
    endtask

    task automatic rect_a(input int r0, input int r1, input int c0_, input int c1);
        for (int r = r0; r <= r1; r++)
            for (int c = c0_; c <= c1; c++) mask_a[r][c] = 1'b1;
    endtask

    task automatic frame(input bit gaps, input int npix);
        for (int p = 0; p < npix; p++) begin
            if (gaps && p > 0) begin
                pixel_valid = 1'b0;
                pixel_skin  = 1'b1;
                frame_start = 1'b0;
                tick();
            end
            pixel_valid = 1'b1;
            pixel_skin  = mask_a[p / W][p % W];
            frame_start = (p == 0);
            tick();
        end
        pixel_valid = 1'b0;
        pixel_skin  = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic tail(input string tag, input int sr, input int sc, input int er,
                        input int ec, input int w, input int h);
        chk({tag, "_bv_early"}, 32'(box_valid), 0);
        chk({tag, "_busy_done"}, 32'(busy), 1);
        tick();
        chk({tag, "_bv_pulse"}, 32'(box_valid), 1);
        chk_box(tag, sr, sc, er, ec, w, h);
        tick();
        chk({tag, "_bv_fall"}, 32'(box_valid), 0);
    endtask

    initial begin
        rst = 1'b1; pixel_valid = 1'b0; pixel_skin = 1'b0; frame_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_bv", 32'(box_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk_box("rst", 0, 0, 0, 0, 0, 0);

        // Empty frame
        clear_masks();
        c0 = bv_count;
        frame(1'b0, N);
        tail("empty", 0, 0, 0, 0, 0, 0);
        chk("empty_pulses", 32'(bv_count - c0), 1);

        // Filled rectangle rows 3..8, cols 5..10, then idle hold
        rect_a(3, 8, 5, 10);
        frame(1'b0, N);
        tail("rect", 3, 5, 8, 10, 6, 6);
        for (int i = 0; i < 5; i++) tick();
        chk_box("hold", 3, 5, 8, 10, 6, 6);
        chk("hold_bv", 32'(box_valid), 0);
        chk("hold_busy", 32'(busy), 0);

        // Same rectangle with valid toggling
        c0 = bv_count;
        frame(1'b1, N);
        tail("gaps", 3, 5, 8, 10, 6, 6);
        chk("gaps_pulses", 32'(bv_count - c0), 1);

        // Aborted frame at pixel 100, then clean frame with skin at (7,9)
        clear_masks();
        mask_a[2][2] = 1'b1;
        c0 = bv_count;
        frame(1'b0, 100);
        clear_masks();
        mask_a[7][9] = 1'b1;
        frame(1'b0, N);
`ifdef PALM_RUN_FILTER_EN
        tail("restart", 0, 0, 0, 0, 0, 0);
`else
        tail("restart", 7, 9, 7, 9, 1, 1);
`endif
        chk("restart_pulses", 32'(bv_count - c0), 1);

        // Isolated pixels plus a 3-pixel run
        clear_masks();
        mask_a[1][1]  = 1'b1;
        mask_a[4][14] = 1'b1;
        rect_a(6, 6, 8, 10);
        frame(1'b0, N);
`ifdef PALM_RUN_FILTER_EN
        tail("runf", 6, 8, 6, 10, 3, 1);
`else
        tail("runf", 1, 1, 6, 14, 14, 6);
`endif

        // Back-to-back frames, second frame_start in the DONE cycle
        clear_masks();
        rect_a(1, 2, 2, 13);
        for (int c = 0; c < 3; c++) mask_b[0][c] = 1'b1;
        for (int c = 13; c < 16; c++) mask_b[11][c] = 1'b1;
        c0 = bv_count;
        for (int p = 0; p < 2 * N; p++) begin
            pixel_valid = 1'b1;
            pixel_skin  = (p < N) ? mask_a[p / W][p % W] : mask_b[(p - N) / W][(p - N) % W];
            frame_start = (p == 0) || (p == N);
            tick();
            if (p == N - 1) chk("b2b_bv_before", 32'(box_valid), 0);
            if (p == N) begin
                chk("b2b_bv_first", 32'(box_valid), 1);
                chk_box("b2b1", 1, 2, 2, 13, 12, 2);
            end
            if (p == N + 1) chk("b2b_bv_after", 32'(box_valid), 0);
        end
        pixel_valid = 1'b0;
        pixel_skin  = 1'b0;
        frame_start = 1'b0;
        tail("b2b2", 0, 0, 11, 15, 16, 12);
        chk("b2b_pulses", 32'(bv_count - c0), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
